// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID->EX pipeline register with stall/flush and Tnew countdown
// Optional macro PIPE_PERF_CNT_EN adds stall_cnt/bubble_cnt performance counters.
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int CTRL_W  = 12,
    parameter int TNEW_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      valid_d,
    input  logic                      reg_write_d,
    input  logic                      mem_write_d,
    input  logic [CTRL_W-1:0]         ctrl_d,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_d,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_d,
    input  logic [ADDR_W-1:0]         dst_addr_d,
    input  logic [DATA_W-1:0]         imm_d,
    input  logic [DATA_W-1:0]         pc_d,
    input  logic [TNEW_W-1:0]         tnew_d,
    output logic                      valid_e,
    output logic                      reg_write_e,
    output logic                      mem_write_e,
    output logic [CTRL_W-1:0]         ctrl_e,
    output logic [NUM_SRC*DATA_W-1:0] src_data_e,
    output logic [NUM_SRC*ADDR_W-1:0] src_addr_e,
    output logic [ADDR_W-1:0]         dst_addr_e,
    output logic [DATA_W-1:0]         imm_e,
    output logic [DATA_W-1:0]         pc_e,
    output logic [TNEW_W-1:0]         tnew_e
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               bubble_cnt
`endif
);

    logic                      slot_valid_q,     slot_valid_d;
    logic                      slot_reg_write_q, slot_reg_write_d;
    logic                      slot_mem_write_q, slot_mem_write_d;
    logic [CTRL_W-1:0]         slot_ctrl_q,      slot_ctrl_d;
    logic [NUM_SRC*DATA_W-1:0] slot_src_data_q,  slot_src_data_d;
    logic [NUM_SRC*ADDR_W-1:0] slot_src_addr_q,  slot_src_addr_d;
    logic [ADDR_W-1:0]         slot_dst_addr_q,  slot_dst_addr_d;
    logic [DATA_W-1:0]         slot_imm_q,       slot_imm_d;
    logic [DATA_W-1:0]         slot_pc_q,        slot_pc_d;
    logic [TNEW_W-1:0]         slot_tnew_q,      slot_tnew_d;
    logic [TNEW_W-1:0]         tnew_dec;

    // Tnew counts down by one on capture but never wraps below zero.
    assign tnew_dec = (tnew_d == '0) ? '0 : tnew_d - TNEW_W'(1);

    always_comb begin
        slot_valid_d     = slot_valid_q;
        slot_reg_write_d = slot_reg_write_q;
        slot_mem_write_d = slot_mem_write_q;
        slot_ctrl_d      = slot_ctrl_q;
        slot_src_data_d  = slot_src_data_q;
        slot_src_addr_d  = slot_src_addr_q;
        slot_dst_addr_d  = slot_dst_addr_q;
        slot_imm_d       = slot_imm_q;
        slot_pc_d        = slot_pc_q;
        slot_tnew_d      = slot_tnew_q;
        if (flush) begin
            // Bubble: zeroed addresses can never match a forwarding or hazard compare.
            slot_valid_d     = 1'b0;
            slot_reg_write_d = 1'b0;
            slot_mem_write_d = 1'b0;
            slot_ctrl_d      = '0;
            slot_src_addr_d  = '0;
            slot_dst_addr_d  = '0;
            slot_tnew_d      = '0;
        end else if (!stall) begin
            slot_valid_d     = valid_d;
            slot_reg_write_d = valid_d & reg_write_d;
            slot_mem_write_d = valid_d & mem_write_d;
            slot_ctrl_d      = ctrl_d;
            slot_src_data_d  = src_data_d;
            slot_src_addr_d  = src_addr_d;
            slot_dst_addr_d  = valid_d ? dst_addr_d : '0;
            slot_imm_d       = imm_d;
            slot_pc_d        = pc_d;
            slot_tnew_d      = valid_d ? tnew_dec : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid_q     <= 1'b0;
            slot_reg_write_q <= 1'b0;
            slot_mem_write_q <= 1'b0;
            slot_ctrl_q      <= '0;
            slot_src_data_q  <= '0;
            slot_src_addr_q  <= '0;
            slot_dst_addr_q  <= '0;
            slot_imm_q       <= '0;
            slot_pc_q        <= '0;
            slot_tnew_q      <= '0;
        end else begin
            slot_valid_q     <= slot_valid_d;
            slot_reg_write_q <= slot_reg_write_d;
            slot_mem_write_q <= slot_mem_write_d;
            slot_ctrl_q      <= slot_ctrl_d;
            slot_src_data_q  <= slot_src_data_d;
            slot_src_addr_q  <= slot_src_addr_d;
            slot_dst_addr_q  <= slot_dst_addr_d;
            slot_imm_q       <= slot_imm_d;
            slot_pc_q        <= slot_pc_d;
            slot_tnew_q      <= slot_tnew_d;
        end
    end

    assign valid_e     = slot_valid_q;
    assign reg_write_e = slot_reg_write_q;
    assign mem_write_e = slot_mem_write_q;
    assign ctrl_e      = slot_ctrl_q;
    assign src_data_e  = slot_src_data_q;
    assign src_addr_e  = slot_src_addr_q;
    assign dst_addr_e  = slot_dst_addr_q;
    assign imm_e       = slot_imm_q;
    assign pc_e        = slot_pc_q;
    assign tnew_e      = slot_tnew_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // An invalid instruction loaded normally is counted as a bubble too.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        else if (stall)
            stall_cnt_d = stall_cnt_q + 32'd1;
        else if (!valid_d)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - scoreboard bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

    typedef struct {
        string       tag;
        logic        v, rw, mw;
        logic [11:0] ctrl;
        logic [63:0] sd;
        logic [9:0]  sa;
        logic [4:0]  dst;
        logic [31:0] imm, pc;
        logic [1:0]  tn;
        logic [31:0] sc, bc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic        valid_d, reg_write_d, mem_write_d;
    logic [11:0] ctrl_d;
    logic [63:0] src_data_d;
    logic [9:0]  src_addr_d;
    logic [4:0]  dst_addr_d;
    logic [31:0] imm_d, pc_d;
    logic [1:0]  tnew_d;
    logic        valid_e, reg_write_e, mem_write_e;
    logic [11:0] ctrl_e;
    logic [63:0] src_data_e;
    logic [9:0]  src_addr_e;
    logic [4:0]  dst_addr_e;
    logic [31:0] imm_e, pc_e;
    logic [1:0]  tnew_e;
    logic [31:0] stall_cnt, bubble_cnt;

    logic [47:0] sd2_d = '0;
    logic [14:0] sa2_d = '0;
    logic [15:0] imm2_d = '0, pc2_d = '0;
    logic        v2_e, rw2_e, mw2_e;
    logic [11:0] ctrl2_e;
    logic [47:0] sd2_e;
    logic [14:0] sa2_e;
    logic [4:0]  dst2_e;
    logic [15:0] imm2_e, pc2_e;
    logic [1:0]  tn2_e;
    logic [31:0] stall2_cnt, bubble2_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_sc = 0;
    int exp_bc = 0;
    exp_t q[$];
    logic [47:0] q2[$];
    event sample_now;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_d(valid_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
        .ctrl_d(ctrl_d), .src_data_d(src_data_d), .src_addr_d(src_addr_d),
        .dst_addr_d(dst_addr_d), .imm_d(imm_d), .pc_d(pc_d), .tnew_d(tnew_d),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .ctrl_e(ctrl_e), .src_data_e(src_data_e), .src_addr_e(src_addr_e),
        .dst_addr_e(dst_addr_e), .imm_e(imm_e), .pc_e(pc_e), .tnew_e(tnew_e)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    id_ex_stage_reg #(.DATA_W(16), .NUM_SRC(3)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_d(1'b1), .reg_write_d(1'b0), .mem_write_d(1'b0),
        .ctrl_d(12'h0), .src_data_d(sd2_d), .src_addr_d(sa2_d),
        .dst_addr_d(5'd1), .imm_d(imm2_d), .pc_d(pc2_d), .tnew_d(2'd0),
        .valid_e(v2_e), .reg_write_e(rw2_e), .mem_write_e(mw2_e),
        .ctrl_e(ctrl2_e), .src_data_e(sd2_e), .src_addr_e(sa2_e),
        .dst_addr_e(dst2_e), .imm_e(imm2_e), .pc_e(pc2_e), .tnew_e(tn2_e)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall2_cnt), .bubble_cnt(bubble2_cnt)
`endif
    );

`ifndef PIPE_PERF_CNT_EN
    assign stall_cnt   = '0;
    assign bubble_cnt  = '0;
    assign stall2_cnt  = '0;
    assign bubble2_cnt = '0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        e = q.pop_front();
        chk({e.tag, ".valid"}, 64'(valid_e), 64'(e.v));
        chk({e.tag, ".reg_write"}, 64'(reg_write_e), 64'(e.rw));
        chk({e.tag, ".mem_write"}, 64'(mem_write_e), 64'(e.mw));
        chk({e.tag, ".ctrl"}, 64'(ctrl_e), 64'(e.ctrl));
        chk({e.tag, ".src_data"}, src_data_e, e.sd);
        chk({e.tag, ".src_addr"}, 64'(src_addr_e), 64'(e.sa));
        chk({e.tag, ".dst_addr"}, 64'(dst_addr_e), 64'(e.dst));
        chk({e.tag, ".imm"}, 64'(imm_e), 64'(e.imm));
        chk({e.tag, ".pc"}, 64'(pc_e), 64'(e.pc));
        chk({e.tag, ".tnew"}, 64'(tnew_e), 64'(e.tn));
`ifdef PIPE_PERF_CNT_EN
        chk({e.tag, ".stall_cnt"}, 64'(stall_cnt), 64'(e.sc));
        chk({e.tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(e.bc));
`endif
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) check_pop();
        if (q2.size() > 0) begin
            logic [47:0] x;
            x = q2.pop_front();
            for (int i = 0; i < 3; i++)
                chk($sformatf("t6.src%0d", i), 64'(sd2_e[i*16 +: 16]), 64'(x[i*16 +: 16]));
        end
    end

    always @(sample_now) if (q.size() > 0) check_pop();

    function automatic exp_t mk(input string tag, input logic v, input logic rw, input logic mw,
                                input logic [11:0] ctrl, input logic [63:0] sd, input logic [9:0] sa,
                                input logic [4:0] dst, input logic [31:0] imm, input logic [31:0] pc,
                                input logic [1:0] tn);
        exp_t e;
        e.tag = tag; e.v = v; e.rw = rw; e.mw = mw; e.ctrl = ctrl; e.sd = sd; e.sa = sa;
        e.dst = dst; e.imm = imm; e.pc = pc; e.tn = tn; e.sc = 0; e.bc = 0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic rw, input logic mw, input logic [11:0] ctrl,
                         input logic [63:0] sd, input logic [9:0] sa, input logic [4:0] dst,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] tn);
        valid_d = v; reg_write_d = rw; mem_write_d = mw; ctrl_d = ctrl; src_data_d = sd;
        src_addr_d = sa; dst_addr_d = dst; imm_d = imm; pc_d = pc; tnew_d = tn;
    endtask

    task automatic tick(input exp_t e);
        @(posedge clk);
        #1;
        if (reset) begin
            exp_sc = 0; exp_bc = 0;
        end else if (flush) exp_bc++;
        else if (stall) exp_sc++;
        else if (!valid_d) exp_bc++;
        e.sc = exp_sc;
        e.bc = exp_bc;
        q.push_back(e);
    endtask

    localparam logic [63:0] SD_A = 64'h2222_2222_1111_1111;
    localparam logic [63:0] SD_C = 64'hDEAD_BEEF_CAFE_F00D;
    exp_t zero_e, e3;

    initial begin
        drive(0, 0, 0, 12'h0, 64'h0, 10'h0, 5'd0, 32'h0, 32'h0, 2'd0);
        zero_e = mk("rst", 0, 0, 0, 12'h0, 64'h0, 10'h0, 5'd0, 32'h0, 32'h0, 2'd0);
        #1 reset = 1'b1;
        #1 q.push_back(zero_e); -> sample_now;
        @(posedge clk); #1; reset = 1'b0;

        drive(1, 1, 0, 12'hA5A, SD_A, 10'h062, 5'd8, 32'h10, 32'h1000, 2'd2);
        tick(mk("ldA", 1, 1, 0, 12'hA5A, SD_A, 10'h062, 5'd8, 32'h10, 32'h1000, 2'd1));

        // Reset asserted mid-cycle must clear outputs without waiting for a clock edge.
        @(negedge clk); #2; reset = 1'b1; #1;
        exp_sc = 0; exp_bc = 0;
        zero_e.tag = "rstmid"; q.push_back(zero_e); -> sample_now;
        zero_e.tag = "rsthold"; tick(zero_e);
        reset = 1'b0;

        drive(1, 0, 0, 12'h001, SD_A, 10'h062, 5'd8, 32'h0, 32'h1004, 2'd2);
        tick(mk("t1", 1, 0, 0, 12'h001, SD_A, 10'h062, 5'd8, 32'h0, 32'h1004, 2'd1));

        drive(1, 1, 0, 12'h002, 64'h5, 10'h021, 5'd9, 32'h20, 32'h2000, 2'd0);
        tick(mk("t2sat", 1, 1, 0, 12'h002, 64'h5, 10'h021, 5'd9, 32'h20, 32'h2000, 2'd0));
        drive(1, 1, 0, 12'h002, 64'h6, 10'h021, 5'd9, 32'h20, 32'h2004, 2'd3);
        tick(mk("t2max", 1, 1, 0, 12'h002, 64'h6, 10'h021, 5'd9, 32'h20, 32'h2004, 2'd2));

        drive(0, 1, 1, 12'h0F0, 64'h77, 10'h0C4, 5'd7, 32'h30, 32'h2008, 2'd3);
        tick(mk("inval", 0, 0, 0, 12'h0F0, 64'h77, 10'h0C4, 5'd0, 32'h30, 32'h2008, 2'd0));

        drive(1, 1, 1, 12'h333, SD_C, 10'h0A5, 5'd12, 32'h44, 32'h3000, 2'd3);
        e3 = mk("t3ld", 1, 1, 1, 12'h333, SD_C, 10'h0A5, 5'd12, 32'h44, 32'h3000, 2'd2);
        tick(e3);
        stall = 1'b1;
        e3.tag = "t3stall";
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 12'hFFF, 64'h0, 10'h3FF, 5'd31, 32'h0, 32'h3000 + 32'(4 * (i + 1)), 2'd0);
            tick(e3);
        end
        stall = 1'b0;

        flush = 1'b1;
        drive(1, 1, 1, 12'h444, 64'h99, 10'h062, 5'd5, 32'h55, 32'h4000, 2'd3);
        tick(mk("t4", 0, 0, 0, 12'h000, SD_C, 10'h000, 5'd0, 32'h44, 32'h3000, 2'd0));
        flush = 1'b0;

        drive(1, 1, 0, 12'h555, 64'h1234, 10'h021, 5'd6, 32'h66, 32'h5000, 2'd1);
        tick(mk("ldB", 1, 1, 0, 12'h555, 64'h1234, 10'h021, 5'd6, 32'h66, 32'h5000, 2'd0));

        flush = 1'b1; stall = 1'b1;
        drive(1, 1, 1, 12'h666, 64'h4321, 10'h3E0, 5'd30, 32'h77, 32'h6000, 2'd3);
        tick(mk("t5", 0, 0, 0, 12'h000, 64'h1234, 10'h000, 5'd0, 32'h66, 32'h5000, 2'd0));
        flush = 1'b0; stall = 1'b0;

        sd2_d = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        drive(1, 0, 1, 12'h777, 64'h8, 10'h001, 5'd2, 32'h88, 32'h7000, 2'd1);
        tick(mk("t6main", 1, 0, 1, 12'h777, 64'h8, 10'h001, 5'd2, 32'h88, 32'h7000, 2'd0));
        q2.push_back(48'hCCCC_BBBB_AAAA);

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(q.size() + q2.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
